// File: rtl/vm_agent_shim_s00_axi_regs_if.sv
// AXI4-Lite bus bundle for the S00_AXI port of the vm_agent_shim register file.
// Handshake rule shared by all five channels: a transfer happens on a rising
// ACLK edge where VALID and READY are both high; once VALID is raised, the
// source holds it and the payload stable until that edge.
interface vm_agent_shim_s00_axi_regs_if #(
    parameter int ADDR_W = 5
);
    // Write address channel
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    // Write data channel
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    // Write response channel
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    // Read address channel
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    // Read data channel
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );
endinterface

// File: rtl/vm_agent_shim_s00_axi_regs.sv
// AXI4-Lite responder holding NUM_REGS 32-bit control registers for the
// vm_agent_shim core. Write address and write data are captured independently
// into holding stages and committed together one edge after both are held.
// Reads answer from the register array one edge after the AR handshake.
// Every READY is decoded from registered state only.
module vm_agent_shim_s00_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    vm_agent_shim_s00_axi_regs_if.slave s00_axi,
    output logic [NUM_REGS*32-1:0]   REG_Q
);

    localparam int         IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam int         STRB_W      = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-side holding stages and response
    logic              aw_held_q, aw_held_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              w_held_q, w_held_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    // Read response
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    // Register array
    logic [31:0]       regs_q [NUM_REGS];
    logic [31:0]       regs_d [NUM_REGS];

    // Handshake and decode helpers
    logic              awready, wready, arready;
    logic              aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic              commit;
    logic              aw_hit, ar_hit;
    logic [IDX_W-1:0]  ar_idx;
    logic [31:0]       ar_word;
    logic              unused_ok;

    // A word index is a hit when it falls inside the implemented register range.
    function automatic logic idx_hit(input logic [IDX_W-1:0] idx);
        return ({{(32-IDX_W){1'b0}}, idx} < 32'(NUM_REGS));
    endfunction

    assign awready = !aw_held_q && !bvalid_q;
    assign wready  = !w_held_q  && !bvalid_q;
    assign arready = !rvalid_q;

    assign aw_hs  = s00_axi.awvalid && awready;
    assign w_hs   = s00_axi.wvalid  && wready;
    assign ar_hs  = s00_axi.arvalid && arready;
    assign b_hs   = bvalid_q && s00_axi.bready;
    assign r_hs   = rvalid_q && s00_axi.rready;

    assign commit = aw_held_q && w_held_q;
    assign aw_hit = idx_hit(aw_idx_q);
    assign ar_idx = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_hit = idx_hit(ar_idx);

    assign s00_axi.awready = awready;
    assign s00_axi.wready  = wready;
    assign s00_axi.arready = arready;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = rresp_q;

    // Protection bits and the byte offset inside a word carry no meaning here.
    assign unused_ok = &{1'b0, s00_axi.awprot, s00_axi.arprot,
                         s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    // Select the current register word addressed by the read request.
    always_comb begin
        ar_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == IDX_W'(k)) begin
                ar_word = regs_q[k];
            end
        end
    end

    // Write path next state: fill holds, commit held beat, retire response.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
        end

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s00_axi.wdata;
            wstrb_d  = s00_axi.wstrb;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_hit ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (aw_hit && (aw_idx_q == IDX_W'(k))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end
    end

    // Read path next state: capture response on AR, retire it on R handshake.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_hit ? ar_word : 32'h0;
            rresp_d  = ar_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    // State registers; reset discards any held beat or pending response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // Flat view of the register array for the shim core.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign REG_Q[32*g +: 32] = regs_q[g];
    end

endmodule

// File: doc/vm_agent_shim_s00_axi_regs.md
# vm_agent_shim_s00_axi_regs

AXI4-Lite responder (slave) register file for the S00_AXI port of the vm_agent_shim: accepts single-beat writes and reads from the master VIP or the system interconnect. It holds NUM_REGS 32-bit control registers. It also exposes their contents as a flat bus to the shim core. Write address and write data channels are independent, with one outstanding write and one outstanding read.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; fixed at 32 and not otherwise supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width. The default decodes 8 word slots.
- NUM_REGS, 4, number of implemented registers at word offsets 0..NUM_REGS-1. Higher slots are unimplemented.
- ACLK  in  1  single clock; all logic on rising edge.
- ARESETN  in  1  reset, asynchronous and active-low.
- S00_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S00_AXI_AWPROT  in  3  accepted, ignored.
- S00_AXI_AWVALID / S00_AXI_AWREADY  in / out  1  write address handshake.
- S00_AXI_WDATA  in  32  write data.
- S00_AXI_WSTRB  in  4  byte enables.
- S00_AXI_WVALID / S00_AXI_WREADY  in / out  1  write data handshake.
- S00_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S00_AXI_BVALID / S00_AXI_BREADY  out / in  1  write response handshake.
- S00_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S00_AXI_ARPROT  in  3  accepted, ignored.
- S00_AXI_ARVALID / S00_AXI_ARREADY  in / out  1  read address handshake.
- S00_AXI_RDATA  out  32  read data.
- S00_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
- S00_AXI_RVALID / S00_AXI_RREADY  out / in  1  read data handshake.
- REG_Q  out  NUM_REGS*32  register contents; register k is at bits [32k+31:32k].

## Operation
- Address decode:
  - Word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] is ignored.
  - Index < NUM_REGS is a hit; any other index is a miss.
- Write path has two holding stages, aw_held (address) and w_held (data and strobe). Each fills independently on its own handshake.
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
- Write commit: on the first edge where aw_held && w_held are both registered high:
  - On a hit, each byte lane with WSTRB[b]=1 is updated and lanes with WSTRB[b]=0 are kept.
  - On a miss, no register changes.
  - BVALID is set; BRESP = 00 on a hit, 10 on a miss.
  - Both holds clear.
- Write response: BVALID and BRESP stay stable until the BREADY handshake edge, at which BVALID clears.
- Read path: ARREADY = !RVALID. On the AR handshake edge:
  - RVALID is set.
  - RDATA = register value before that edge (hit) or 0 (miss).
  - RRESP = 00 (hit) or 10 (miss).
- Read response: RVALID, RDATA and RRESP stay stable until the RREADY handshake edge, at which RVALID clears.
- Read and write paths are fully independent. Neither blocks the other.
- REG_Q updates on the commit edge.

## Timing
- Reset values (asserted immediately and asynchronously):
  - All registers and REG_Q = 0.
  - aw_held = w_held = 0.
  - BVALID = RVALID = 0; BRESP = RRESP = 00; RDATA = 0.
  - AWREADY = WREADY = ARREADY = 1 from the first cycle after release.
- Write latency: with AW and W handshaking on the same edge N, BVALID is high after edge N+1.
- Skewed AW and W: if the later of the two handshakes at edge M, BVALID is high after edge M+1. Skew is unbounded in either order.
- Write throughput with BREADY tied high: one write per 3 cycles.
- Read latency: AR handshake at edge N → RVALID high after edge N.
- Read throughput with RREADY tied high: one read per 2 cycles.
- Same-edge read/write collision: a write commit and an AR handshake to the same register on the same edge → read returns the old value.
- Reset mid-operation: any held AW/W, pending B or pending R is discarded. No response is issued after ARESETN is released.
- All READY outputs are decoded only from registered state. There is no combinational path from any VALID input to any READY output.

## Test plan
- Reset: hold ARESETN low 200 ns → BVALID=RVALID=0 and REG_Q=0 during reset; afterwards reads of 0x0..0xC return 0 with RRESP=00.
- Sequential writes: data 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, WSTRB=0xF → BRESP=00 each time and REG_Q = {4,3,2,1}. Readback returns 0x1..0x4, each one cycle after its AR handshake.
- Skew: W=0xA5A5A5A5 presented 3 cycles before AW=0x8 → WREADY drops after the W handshake; BVALID rises one edge after the AW handshake; readback of 0x8 = 0xA5A5A5A5.
- Strobes: reg1=0x12345678, then write 0xFFFFFFFF with WSTRB=0101 → reg1 reads 0x12FF56FF.
- Miss: write 0x10 → BRESP=10 and REG_Q unchanged; read 0x14 → RDATA=0, RRESP=10.
- Backpressure and reset:
  - Hold BREADY and RREADY low 5 cycles → BVALID, BRESP, RVALID and RDATA stay stable, and AWREADY, WREADY and ARREADY stay low.
  - Assert ARESETN low mid-hold → BVALID and RVALID go to 0 without waiting for a clock edge.
